plab4_net_router_output_sched: RTL and testbench

Per-output-port scheduler for the 3-port ring router. It arbitrates among the three input-port requesters (west, terminal, east) for one output port and drives that port's crossbar select and `out_val`. It returns a one-hot grant to the winning input controller. It replaces the stateless round-robin output control with a scheduler that locks the grant while a message is stalled and, optionally, ages starving requesters.

---
 rtl/plab4_net_router_output_sched_if.sv | 20 ++
 rtl/plab4_net_router_output_sched.sv | 122 ++++++++++++
 tb/tb_plab4_net_router_output_sched.sv | 122 ++++++++++++
 3 files changed

// File: rtl/plab4_net_router_output_sched_if.sv
// Request/grant and output-link handshake bundle for one router output port.
// The master side is the scheduler; the slave side is the input controllers plus the output link.
interface plab4_net_router_output_sched_if;
  logic [2:0] reqs;
  logic [2:0] grants;
  logic       out_val;
  logic       out_rdy;
  logic [1:0] xbar_sel;
  logic       locked;

  modport master (
    input  reqs, out_rdy,
    output grants, out_val, xbar_sel, locked
  );

  modport slave (
    output reqs, out_rdy,
    input  grants, out_val, xbar_sel, locked
  );
endinterface

// File: rtl/plab4_net_router_output_sched.sv
// Output-port scheduler for the 3-port ring router: round-robin arbitration with a grant lock while stalled.
// Optional starvation aging is compiled in by defining PLAB4_NET_ROUTER_SCHED_AGE_EN.
module plab4_net_router_output_sched #(
  parameter int p_num_reqs  = 3,
  parameter int p_age_limit = 8,
  parameter int p_age_nbits = 4
) (
  input logic clk,
  input logic reset,
  plab4_net_router_output_sched_if.master io
);

  if (p_num_reqs != 3 || p_age_limit < 1 || p_age_limit >= (1 << p_age_nbits)) begin : g_bad_cfg
    $error("plab4_net_router_output_sched: illegal parameter combination");
  end

  typedef enum logic {ARB, HOLD} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] held;

  logic       rr_val;
  logic [1:0] rr_idx;
  logic       starve_val;
  logic [1:0] starve_idx;
  logic       win_val;
  logic [1:0] win_idx;
  logic       xfer;

  // Addition modulo 3 on 2-bit port indices.
  function automatic logic [1:0] wrap_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Scan from the farthest slot back to ptr so the slot nearest ptr is the last to claim the win.
  always_comb begin
    // NOTE: every combinationally written signal gets a default first, so no path leaves it unassigned (no latch).
    rr_val = 1'b0;
    rr_idx = 2'd0;
    for (int k = p_num_reqs - 1; k >= 0; k--) begin
      if (io.reqs[wrap_add(ptr, 2'(k))]) begin
        rr_val = 1'b1;
        rr_idx = wrap_add(ptr, 2'(k));
      end
    end
  end

`ifdef PLAB4_NET_ROUTER_SCHED_AGE_EN
  localparam logic [p_age_nbits-1:0] age_max = p_age_nbits'(p_age_limit);

  logic [p_age_nbits-1:0] age [p_num_reqs];

  always_comb begin
    starve_val = 1'b0;
    starve_idx = 2'd0;
    for (int k = p_num_reqs - 1; k >= 0; k--) begin
      if (io.reqs[k] && age[k] == age_max) begin
        starve_val = 1'b1;
        starve_idx = 2'(k);
      end
    end
  end

  // NOTE: this is a three-entry flop array, not a RAM, so it is reset like any other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < p_num_reqs; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < p_num_reqs; i++) begin
        if (!io.reqs[i] || (xfer && win_idx == 2'(i))) age[i] <= '0;
        else if (age[i] != age_max)                    age[i] <= age[i] + 1'b1;
      end
    end
  end
`else
  assign starve_val = 1'b0;
  assign starve_idx = 2'd0;
`endif

  // A stalled message keeps the port; starvation only overrides round-robin in ARB.
  always_comb begin
    win_val = 1'b0;
    win_idx = 2'd0;
    if (state == HOLD && io.reqs[held]) begin
      win_val = 1'b1;
      win_idx = held;
    end else if (starve_val) begin
      win_val = 1'b1;
      win_idx = starve_idx;
    end else if (rr_val) begin
      win_val = 1'b1;
      win_idx = rr_idx;
    end
  end

  assign xfer        = win_val && io.out_rdy;
  assign io.out_val  = win_val;
  assign io.xbar_sel = win_idx;
  assign io.grants   = xfer ? 3'(3'b001 << win_idx) : 3'b000;
  assign io.locked   = (state == HOLD);

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state <= ARB;
      ptr   <= 2'd0;
      held  <= 2'd0;
    end else if (xfer) begin
      state <= ARB;
      ptr   <= wrap_add(win_idx, 2'd1);
    end else if (win_val) begin
      state <= HOLD;
      held  <= win_idx;
    end else begin
      state <= ARB;
    end
  end

endmodule

// File: tb/tb_plab4_net_router_output_sched.sv
// Directed scoreboard bench for plab4_net_router_output_sched; expected outputs are queued per cycle
// and popped by an independent monitor on the falling edge.
module tb_plab4_net_router_output_sched;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  plab4_net_router_output_sched_if bus ();

  plab4_net_router_output_sched #(
    .p_num_reqs  (3),
    .p_age_limit (2),
    .p_age_nbits (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  typedef struct {
    logic [6:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got grants=%b val=%b sel=%0d locked=%b, want grants=%b val=%b sel=%0d locked=%b",
               tag, act[6:4], act[3], act[2:1], act[0], exp[6:4], exp[3], exp[2:1], exp[0]);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge and queue the response it must produce.
  task automatic step(input logic r, input logic [2:0] rq, input logic rdy,
                      input logic [2:0] g, input logic v, input logic [1:0] s, input logic l,
                      input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset       = r;
    bus.reqs    = rq;
    bus.out_rdy = rdy;
    e.exp = {g, v, s, l};
    e.tag = tag;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.tag, {bus.grants, bus.out_val, bus.xbar_sel, bus.locked}, e.exp);
      end
    end
  end

  initial begin : stimulus
    bus.reqs    = 3'b000;
    bus.out_rdy = 1'b0;

    // Reset and idle
    step(1, 3'b000, 1, 3'b000, 0, 2'd0, 0, "reset_idle");

    // Round-robin with all ports requesting
    step(0, 3'b111, 1, 3'b001, 1, 2'd0, 0, "rr_0");
    step(0, 3'b111, 1, 3'b010, 1, 2'd1, 0, "rr_1");
    step(0, 3'b111, 1, 3'b100, 1, 2'd2, 0, "rr_2");
    step(0, 3'b111, 1, 3'b001, 1, 2'd0, 0, "rr_wrap_0");
    step(0, 3'b111, 1, 3'b010, 1, 2'd1, 0, "rr_wrap_1");
    step(0, 3'b111, 1, 3'b100, 1, 2'd2, 0, "rr_wrap_2");

    // Lock on port 0 while stalled; port 1 cannot preempt
    step(0, 3'b011, 0, 3'b000, 1, 2'd0, 0, "lock_stall_0");
    step(0, 3'b011, 0, 3'b000, 1, 2'd0, 1, "lock_stall_1");
    step(0, 3'b011, 0, 3'b000, 1, 2'd0, 1, "lock_stall_2");
    step(0, 3'b111, 1, 3'b001, 1, 2'd0, 1, "lock_release");
    step(0, 3'b111, 1, 3'b010, 1, 2'd1, 0, "lock_next_ptr1");

    // Held request drops while in HOLD on port 2
    step(0, 3'b100, 0, 3'b000, 1, 2'd2, 0, "drop_stall_p2");
    step(0, 3'b001, 1, 3'b001, 1, 2'd0, 1, "drop_rearb_p0");
    step(0, 3'b000, 1, 3'b000, 0, 2'd0, 0, "drop_unlocked");

    // Port 0 waits under a lock on port 1 until its age saturates, then ptr moves to 2
    step(0, 3'b011, 0, 3'b000, 1, 2'd1, 0, "age_stall_0");
    step(0, 3'b011, 0, 3'b000, 1, 2'd1, 1, "age_stall_1");
    step(0, 3'b011, 1, 3'b010, 1, 2'd1, 1, "age_release_p1");
`ifdef PLAB4_NET_ROUTER_SCHED_AGE_EN
    step(0, 3'b101, 1, 3'b001, 1, 2'd0, 0, "age_starved_p0");
    step(0, 3'b101, 1, 3'b100, 1, 2'd2, 0, "age_then_p2");
`else
    step(0, 3'b101, 1, 3'b100, 1, 2'd2, 0, "noage_rr_p2");
    step(0, 3'b101, 1, 3'b001, 1, 2'd0, 0, "noage_rr_p0");
`endif

    // Reset while locked on port 1 drops the lock without a clock edge
    step(0, 3'b010, 0, 3'b000, 1, 2'd1, 0, "rst_stall_0");
    step(0, 3'b010, 0, 3'b000, 1, 2'd1, 1, "rst_stall_1");
    step(1, 3'b000, 0, 3'b000, 0, 2'd0, 0, "rst_in_hold");
    step(0, 3'b110, 1, 3'b010, 1, 2'd1, 0, "rst_first_arb");
    step(0, 3'b110, 1, 3'b100, 1, 2'd2, 0, "rst_second_arb");

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
